// File: rtl/riscv_pkg.sv
// Shared RV32 load/store constants, LSU state encoding and access-formatting helpers.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_REQ    = 2'd1,
      LSU_WAIT_R = 2'd2
   } lsu_state_t;

   // Stores only have the three signed-size encodings; the unsigned ones are load-only.
   function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                         input logic [1:0] off);
      logic ok;
      case (f3)
         F3_LB:   ok = 1'b1;
         F3_LH:   ok = ~off[0];
         F3_LW:   ok = (off == 2'b00);
         F3_LBU:  ok = ~is_store;
         F3_LHU:  ok = ~is_store & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] size_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] data);
      logic [XLEN-1:0] w;
      case (f3[1:0])
         2'b00:   w = {4{data[7:0]}};
         2'b01:   w = {2{data[15:0]}};
         default: w = data;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a read word and sign- or zero-extends it.
module load_align
   import riscv_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[8*offset +: 8];
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
      data     = '0;
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {24'd0, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data = {16'd0, half_sel};
         F3_LW:   data = rdata;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: formats accesses for a req/gnt/rvalid data port,
// stalls the pipeline until completion and aborts accesses that wait too long.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int MAX_WAIT = 255
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] store_data,
   output logic            stall,
   output logic [XLEN-1:0] load_data,
   output logic            load_valid,
   output logic            access_err,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata
);

   localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   lsu_state_t      state, state_next;
   logic [WCW-1:0]  wait_cnt;
   logic [XLEN-1:0] lat_addr;
   logic [XLEN-1:0] lat_wdata;
   logic [3:0]      lat_be;
   logic            lat_we;
   logic [2:0]      lat_funct3;
   logic [1:0]      lat_off;
   logic            latch_en;

   logic            access;
   logic            is_store;
   logic            legal;
   logic            timeout;
   logic [XLEN-1:0] word_addr;
   logic [3:0]      new_be;
   logic [XLEN-1:0] new_wdata;
   logic [XLEN-1:0] aligned_data;

   // Gating with rst_n keeps a held request from reaching the port while reset is low.
   assign access    = rst_n & (mem_read | mem_write);
   assign is_store  = mem_write;
   assign legal     = access_legal(is_store, funct3, addr[1:0]);
   assign word_addr = {addr[XLEN-1:2], 2'b00};
   assign new_be    = size_be(funct3, addr[1:0]);
   assign new_wdata = is_store ? store_lanes(funct3, store_data) : '0;
   assign timeout   = (MAX_WAIT != 0) && (wait_cnt == WCW'(MAX_WAIT - 1));

   load_align u_load_align (
      .funct3 (lat_funct3),
      .offset (lat_off),
      .rdata  (dmem_rdata),
      .data   (aligned_data)
   );

   always_comb begin
      state_next = state;
      latch_en   = 1'b0;
      stall      = 1'b0;
      load_data  = '0;
      load_valid = 1'b0;
      access_err = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_be    = 4'b0000;
      dmem_wdata = '0;
      case (state)
         LSU_IDLE: begin
            if (access && !legal) begin
               access_err = 1'b1;
            end else if (access) begin
               dmem_req   = 1'b1;
               dmem_we    = is_store;
               dmem_addr  = word_addr;
               dmem_be    = new_be;
               dmem_wdata = new_wdata;
               latch_en   = 1'b1;
               if (!dmem_gnt) begin
                  stall      = 1'b1;
                  state_next = LSU_REQ;
               end else if (!is_store) begin
                  stall      = 1'b1;
                  state_next = LSU_WAIT_R;
               end
            end
         end
         LSU_REQ: begin
            // The abort cycle drops the request, so a grant arriving then is ignored.
            if (timeout) begin
               access_err = 1'b1;
               state_next = LSU_IDLE;
            end else begin
               dmem_req   = 1'b1;
               dmem_we    = lat_we;
               dmem_addr  = lat_addr;
               dmem_be    = lat_be;
               dmem_wdata = lat_wdata;
               if (!dmem_gnt) begin
                  stall = 1'b1;
               end else if (lat_we) begin
                  state_next = LSU_IDLE;
               end else begin
                  stall      = 1'b1;
                  state_next = LSU_WAIT_R;
               end
            end
         end
         LSU_WAIT_R: begin
            if (timeout) begin
               access_err = 1'b1;
               state_next = LSU_IDLE;
            end else if (dmem_rvalid) begin
               load_valid = 1'b1;
               load_data  = aligned_data;
               state_next = LSU_IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_next = LSU_IDLE;
      endcase
   end

   // The wait counter only runs while an access is outstanding past its first cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= LSU_IDLE;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if (state_next == LSU_IDLE) begin
            wait_cnt <= '0;
         end else if (state != LSU_IDLE) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_be     <= 4'b0000;
         lat_we     <= 1'b0;
         lat_funct3 <= 3'b000;
         lat_off    <= 2'b00;
      end else if (latch_en) begin
         lat_addr   <= word_addr;
         lat_wdata  <= new_wdata;
         lat_be     <= new_be;
         lat_we     <= is_store;
         lat_funct3 <= funct3;
         lat_off    <= addr[1:0];
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a transaction-level timing and formatting model.
module tb_load_store_unit;

   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        access_err;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MAX_WAIT(MW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .funct3      (funct3),
      .addr        (addr),
      .store_data  (store_data),
      .stall       (stall),
      .load_data   (load_data),
      .load_valid  (load_valid),
      .access_err  (access_err),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_be     (dmem_be),
      .dmem_wdata  (dmem_wdata),
      .dmem_gnt    (dmem_gnt),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata)
   );

   // One access: grant arrives g cycles after the first request cycle, read data r cycles after grant.
   task automatic run_txn(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                          input int g, input int r);
      logic        st, ld, valid, aborted;
      logic        req_e, stall_e, err_e, lv_e;
      logic [1:0]  off;
      logic [31:0] b, h, ld_e, wd_e, addr_e;
      logic [3:0]  be_e;
      int          done_t, end_t;
      st  = wr;
      ld  = rd && !wr;
      off = a[1:0];
      case (f3)
         3'd0:    valid = 1'b1;
         3'd1:    valid = !a[0];
         3'd2:    valid = (off == 2'd0);
         3'd4:    valid = !st;
         3'd5:    valid = !st && !a[0];
         default: valid = 1'b0;
      endcase
      b = (rdat >> (8 * off)) & 32'hFF;
      h = (rdat >> (16 * off[1])) & 32'hFFFF;
      case (f3)
         3'd0:    ld_e = (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
         3'd4:    ld_e = b;
         3'd1:    ld_e = (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
         3'd5:    ld_e = h;
         default: ld_e = rdat;
      endcase
      if (f3[1:0] == 2'd0) begin
         be_e = 4'd1 << off;
         wd_e = (d & 32'hFF) * 32'h01010101;
      end else if (f3[1:0] == 2'd1) begin
         be_e = 4'd3 << off;
         wd_e = (d & 32'hFFFF) * 32'h00010001;
      end else begin
         be_e = 4'hF;
         wd_e = d;
      end
      if (!st) wd_e = 32'd0;
      addr_e  = a & 32'hFFFFFFFC;
      aborted = 1'b0;
      if (!valid) begin
         end_t = 0;
      end else begin
         done_t = st ? g : g + r;
         if (done_t == 0 || done_t < MW) begin
            end_t = done_t;
         end else begin
            end_t   = MW;
            aborted = 1'b1;
         end
      end
      mem_read   = rd;
      mem_write  = wr;
      funct3     = f3;
      addr       = a;
      store_data = d;
      for (int t = 0; t <= end_t; t++) begin
         dmem_gnt    = (t == g) || (valid && t > g && $urandom_range(1, 0) == 1);
         dmem_rvalid = (ld && t == g + r) || (t <= g && $urandom_range(1, 0) == 1);
         dmem_rdata  = (t == g + r) ? rdat : $urandom;
         @(negedge clk);
         req_e   = valid && t <= g && !(aborted && t == end_t);
         stall_e = valid && t < end_t;
         err_e   = (t == end_t) && (!valid || aborted);
         lv_e    = ld && valid && !aborted && t == end_t;
         n_cmp++;
         if (stall !== stall_e) begin n_bad++; $display("[TB] FAIL %s t=%0d stall got %b want %b", name, t, stall, stall_e); end
         n_cmp++;
         if (dmem_req !== req_e) begin n_bad++; $display("[TB] FAIL %s t=%0d dmem_req got %b want %b", name, t, dmem_req, req_e); end
         n_cmp++;
         if (access_err !== err_e) begin n_bad++; $display("[TB] FAIL %s t=%0d access_err got %b want %b", name, t, access_err, err_e); end
         n_cmp++;
         if (load_valid !== lv_e) begin n_bad++; $display("[TB] FAIL %s t=%0d load_valid got %b want %b", name, t, load_valid, lv_e); end
         n_cmp++;
         if (load_data !== (lv_e ? ld_e : 32'd0)) begin n_bad++; $display("[TB] FAIL %s t=%0d load_data got %h want %h", name, t, load_data, lv_e ? ld_e : 32'd0); end
         n_cmp++;
         if (dmem_we !== (req_e && st)) begin n_bad++; $display("[TB] FAIL %s t=%0d dmem_we got %b want %b", name, t, dmem_we, req_e && st); end
         n_cmp++;
         if (dmem_addr !== (req_e ? addr_e : 32'd0)) begin n_bad++; $display("[TB] FAIL %s t=%0d dmem_addr got %h want %h", name, t, dmem_addr, req_e ? addr_e : 32'd0); end
         n_cmp++;
         if (dmem_be !== (req_e ? be_e : 4'd0)) begin n_bad++; $display("[TB] FAIL %s t=%0d dmem_be got %b want %b", name, t, dmem_be, req_e ? be_e : 4'd0); end
         n_cmp++;
         if (dmem_wdata !== (req_e ? wd_e : 32'd0)) begin n_bad++; $display("[TB] FAIL %s t=%0d dmem_wdata got %h want %h", name, t, dmem_wdata, req_e ? wd_e : 32'd0); end
         if (t < end_t) begin
            @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      mem_read    = 1'b1;
      funct3      = 3'd2;
      addr        = 32'h40;
      dmem_gnt    = 1'b1;
      dmem_rvalid = 1'b1;
      #3;
      n_cmp++;
      if ({dmem_req, stall, load_valid, access_err} !== 4'b0) begin n_bad++; $display("[TB] FAIL reset ctrl got %b want 0000", {dmem_req, stall, load_valid, access_err}); end
      n_cmp++;
      if ({dmem_addr, dmem_be, dmem_wdata, load_data, dmem_we} !== '0) begin n_bad++; $display("[TB] FAIL reset data got nonzero want zero addr=%h be=%b", dmem_addr, dmem_be); end
      mem_read    = 1'b0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 6; i++) begin
         dmem_gnt    = $urandom_range(1, 0) == 1;
         dmem_rvalid = $urandom_range(1, 0) == 1;
         dmem_rdata  = $urandom;
         @(negedge clk);
         n_cmp++;
         if ({dmem_req, stall, load_valid, access_err, dmem_we} !== 5'b0) begin n_bad++; $display("[TB] FAIL idle ctrl got %b want 00000", {dmem_req, stall, load_valid, access_err, dmem_we}); end
         n_cmp++;
         if ({dmem_addr, dmem_be, dmem_wdata, load_data} !== '0) begin n_bad++; $display("[TB] FAIL idle data got %h/%b/%h/%h want zero", dmem_addr, dmem_be, dmem_wdata, load_data); end
         @(posedge clk);
         #1;
      end
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   task automatic test_directed();
      run_txn("sw_imm",     1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
      run_txn("sb_delay",   1'b0, 1'b1, 3'd0, 32'h103, 32'h0000005A, 32'h0, 3, 1);
      run_txn("lb_sign",    1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 32'h00800000, 0, 1);
      run_txn("lbu_zero",   1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 32'h00800000, 1, 2);
      run_txn("lw_mis",     1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1);
      run_txn("lw_timeout", 1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 32'h12345678, 0, 10);
      run_txn("sw_timeout", 1'b0, 1'b1, 3'd2, 32'h204, 32'hCAFEF00D, 32'h0, 6, 1);
      run_txn("sh_hi",      1'b0, 1'b1, 3'd1, 32'h302, 32'h0000BEEF, 32'h0, 1, 1);
      run_txn("lh_hi",      1'b1, 1'b0, 3'd1, 32'h302, 32'h0, 32'h8001FFFF, 0, 3);
      run_txn("lhu_mis",    1'b1, 1'b0, 3'd5, 32'h301, 32'h0, 32'h0, 0, 1);
      run_txn("both_store", 1'b1, 1'b1, 3'd0, 32'h401, 32'h000000C3, 32'h0, 0, 1);
      run_txn("ld_f3_bad",  1'b1, 1'b0, 3'd3, 32'h500, 32'h0, 32'h0, 0, 1);
      run_txn("st_lbu_bad", 1'b0, 1'b1, 3'd4, 32'h500, 32'h0, 32'h0, 0, 1);
   endtask

   task automatic test_reset_mid();
      mem_read   = 1'b1;
      funct3     = 3'd2;
      addr       = 32'h40;
      dmem_gnt   = 1'b1;
      @(posedge clk);
      #1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hA5A5A5A5;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({dmem_req, stall, load_valid} !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_mid ctrl got %b want 000", {dmem_req, stall, load_valid}); end
      n_cmp++;
      if (load_data !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_mid load_data got %h want 00000000", load_data); end
      mem_read    = 1'b0;
      dmem_rvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_txn("after_rst", 1'b1, 1'b0, 3'd1, 32'h42, 32'h0, 32'h7FFF1234, 0, 1);
   endtask

   task automatic test_random();
      int          op;
      logic [31:0] a;
      for (int i = 0; i < 50; i++) begin
         op = $urandom_range(2, 0);
         a  = $urandom;
         run_txn("random", op != 1, op != 0, 3'($urandom_range(7, 0)), a, $urandom, $urandom,
                 $urandom_range(4, 0), $urandom_range(4, 1));
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_idle();
      test_directed();
      test_reset_mid();
      test_random();
      test_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MAX_WAIT, default 255: cycles an access may spend waiting for grant or read data before it is aborted; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mem_read  input  1  EX/MEM load request.
REQ-005 mem_write  input  1  EX/MEM store request.
REQ-006 funct3  input  3  access size and sign (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW).
REQ-007 addr  input  XLEN  effective address (EX/MEM ALU result).
REQ-008 store_data  input  XLEN  forwarded rs2 value.
REQ-009 stall  output  1  holds IF through MEM while the access is incomplete.
REQ-010 load_data  output  XLEN  aligned, extended load result.
REQ-011 load_valid  output  1  load_data valid this cycle.
REQ-012 access_err  output  1  one-cycle pulse for a misaligned, unsupported or timed-out access.
REQ-013 dmem_req  output  1  data memory request.
REQ-014 dmem_we  output  1  1 = write.
REQ-015 dmem_addr  output  XLEN  word address {addr[XLEN-1:2],2'b00}.
REQ-016 dmem_be  output  4  byte enables.
REQ-017 dmem_wdata  output  XLEN  lane-replicated store data.
REQ-018 dmem_gnt  input  1  request accepted this cycle.
REQ-019 dmem_rvalid  input  1  dmem_rdata valid.
REQ-020 dmem_rdata  input  XLEN  read word.

Function
REQ-021 The FSM SHALL have the states IDLE, REQ (waiting for grant) and WAIT_R (waiting for read data).
REQ-022 In IDLE with a valid access, dmem_req SHALL assert in the same cycle, and address, be, wdata, funct3 and the byte offset SHALL be latched.
- If dmem_gnt is sampled high in that cycle: a store completes with stall=0 and the FSM stays in IDLE; a load goes to WAIT_R with stall=1.
- If dmem_gnt is low, the FSM goes to REQ with stall=1.
REQ-023 In REQ, dmem_req SHALL be driven from the latched values.
- On dmem_gnt, a store completes with stall=0 and the FSM goes to IDLE.
- On dmem_gnt, a load goes to WAIT_R.
REQ-024 In WAIT_R, dmem_req SHALL be 0; on dmem_rvalid, load_valid=1, stall=0, load_data is formatted combinationally from dmem_rdata, and the FSM goes to IDLE.
REQ-025 An access SHALL complete in 1 cycle minimum for a store and 2 cycles minimum for a load.
REQ-026 Store formatting:
- SB: wdata={4{byte}}, be=4'b0001<<addr[1:0].
- SH: wdata={2{half}}, be=4'b0011<<addr[1:0].
- SW: be=4'b1111.
REQ-027 Load formatting:
- LB/LBU: sign- or zero-extend rdata[8*off+:8].
- LH/LHU: sign- or zero-extend rdata[16*off[1]+:16].
- LW: rdata unchanged.
REQ-028 Misaligned accesses (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) and unsupported funct3 SHALL issue no request and pulse access_err with stall=0.
REQ-029 mem_read and mem_write asserted together SHALL be handled as a store.
REQ-030 A wait counter SHALL count cycles spent in REQ or WAIT_R. When it reaches MAX_WAIT (and MAX_WAIT≠0), the access SHALL be aborted: dmem_req=0, access_err=1, stall=0, FSM to IDLE.
REQ-031 A dmem_rvalid that is not expected, or a dmem_gnt while dmem_req=0, SHALL be ignored.
REQ-032 When the block is idle with no access, all outputs SHALL be 0.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately return the FSM to IDLE, clear the counter and latches, and drive all outputs to 0, including when asserted mid-access.
REQ-034 After reset release, the first access SHALL behave as REQ-022.

Structure
REQ-035 The F3 load/store constants and the lsu_state_t enum SHALL live in riscv_pkg.
REQ-036 Load extraction and extension SHALL be a sub-module, load_align.

Verification
REQ-037 SW addr=0x100, data=0xDEADBEEF, gnt immediate -> be=1111, dmem_addr=0x100, stall=0.
REQ-038 SB addr=0x103, data=0x5A, gnt delayed 3 cycles -> wdata=0x5A5A5A5A, be=1000, stall high for 3 cycles.
REQ-039 LB addr=0x102 with rdata=0x00800000 -> load_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 LW addr=0x101 -> no dmem_req, access_err pulses once, stall=0.
REQ-041 LW with gnt but no rvalid and MAX_WAIT=4 -> abort after 4 cycles with access_err=1.
REQ-042 rst_n dropped in WAIT_R -> dmem_req, stall and load_valid go to 0 asynchronously; the next access proceeds normally.
